// File: rtl/cmov_wb_ctrl_pkg.sv
// Shared encodings for the conditional-move write-back controller.
// Holds the request opcodes, FSM states, write-port record and saturating counter helper.
package cmov_wb_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_MOVZ  = 2'b01,
    OP_MOVN  = 2'b10,
    OP_NONE  = 2'b11
  } req_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_RT = 2'd1,
    ST_ISSUE   = 2'd2
  } state_e;

  // A pending move may lose the write port to loads this many times in a row.
  localparam logic [1:0] LOSS_MAX = 2'd2;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } rf_wr_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cmov_wb_ctrl_cond.sv
// Condition evaluator: opcode plus rt operand decide write vs. counted squash.
// Purely combinational, zero latency, no flow control.
module cmov_cond
  import cmov_wb_ctrl_pkg::*;
(
  input  req_op_e     op,
  input  logic [4:0]  rd,
  input  logic [31:0] rt,
  output logic        do_write,
  output logic        do_squash
);

  logic rt_zero;
  logic cond_true;
  logic is_cmov;

  assign rt_zero = (rt == 32'd0);

  always_comb begin
    cond_true = 1'b0;
    is_cmov   = 1'b0;
    case (op)
      OP_WRITE: cond_true = 1'b1;
      OP_MOVZ: begin
        cond_true = rt_zero;
        is_cmov   = 1'b1;
      end
      OP_MOVN: begin
        cond_true = !rt_zero;
        is_cmov   = 1'b1;
      end
      default: cond_true = 1'b0;
    endcase
  end

  // Writes to r0 are discarded outright and never count as a squash.
  assign do_write  = cond_true && (rd != 5'd0);
  assign do_squash = is_cmov && !cond_true && (rd != 5'd0);

endmodule

// File: rtl/cmov_wb_ctrl.sv
// Conditional-move write-back controller: captures one move, resolves its condition, shares the RF write port with loads.
// One-cycle accept-to-write latency; req_ready only while idle; loads win the port until a move has lost twice.
module cmov_wb_ctrl
  import cmov_wb_ctrl_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [4:0]  req_rd,
  input  logic [31:0] req_rs_data,
  input  logic [31:0] req_rt_data,
  input  logic        req_rt_valid,
  input  logic        fwd_valid,
  input  logic [31:0] fwd_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [15:0] squash_cnt
);

  state_e      state;
  req_op_e     cap_op;
  logic [4:0]  cap_rd;
  logic [31:0] cap_rs;
  logic [1:0]  loss_cnt;
  logic [15:0] squash_q;

  logic        accept;
  logic        eval_now;
  req_op_e     eval_op;
  logic [4:0]  eval_rd;
  logic [31:0] eval_rt;
  logic        cond_write;
  logic        cond_squash;
  logic        ld_grant;
  logic        issue_grant;
  rf_wr_t      wr;

  assign req_ready = Rst_n && (state == ST_IDLE);
  assign accept    = req_ready && req_valid;

  // One evaluator serves both the same-cycle and the forwarded-operand paths.
  assign eval_op  = (state == ST_IDLE) ? req_op_e'(req_op) : cap_op;
  assign eval_rd  = (state == ST_IDLE) ? req_rd : cap_rd;
  assign eval_rt  = (state == ST_IDLE) ? req_rt_data : fwd_data;
  assign eval_now = (accept && req_rt_valid) || (state == ST_WAIT_RT && fwd_valid);

  cmov_cond u_cond (
    .op        (eval_op),
    .rd        (eval_rd),
    .rt        (eval_rt),
    .do_write  (cond_write),
    .do_squash (cond_squash)
  );

  // loss_cnt only leaves zero while in ISSUE, so this matches the ISSUE-starvation rule.
  assign ld_grant    = Rst_n && ld_valid && (loss_cnt < LOSS_MAX);
  assign ld_ready    = ld_grant;
  assign issue_grant = Rst_n && (state == ST_ISSUE) && !ld_grant;

  always_comb begin
    wr = '0;
    if (ld_grant) begin
      if (ld_rd != 5'd0) begin
        wr = '{we: 1'b1, addr: ld_rd, data: ld_data};
      end
    end else if (issue_grant) begin
      wr = '{we: 1'b1, addr: cap_rd, data: cap_rs};
    end
  end

  assign rf_we      = wr.we;
  assign rf_waddr   = wr.addr;
  assign rf_wdata   = wr.data;
  assign squash_cnt = squash_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= ST_IDLE;
      cap_op   <= OP_WRITE;
      cap_rd   <= 5'd0;
      cap_rs   <= 32'd0;
      loss_cnt <= 2'd0;
      squash_q <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            cap_op <= req_op_e'(req_op);
            cap_rd <= req_rd;
            cap_rs <= req_rs_data;
            if (!req_rt_valid) begin
              state <= ST_WAIT_RT;
            end else if (cond_write) begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_WAIT_RT: begin
          if (fwd_valid) begin
            state <= cond_write ? ST_ISSUE : ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (issue_grant) begin
            state    <= ST_IDLE;
            loss_cnt <= 2'd0;
          end else begin
            loss_cnt <= loss_cnt + 2'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (eval_now && cond_squash) begin
        squash_q <= sat_inc16(squash_q);
      end
    end
  end

endmodule

// File: tb/tb_cmov_wb_ctrl.sv
// Bench for cmov_wb_ctrl: directed vector table, multi-cycle corner sequences, and random traffic
// checked against a pending-move reference model.
module tb_cmov_wb_ctrl;

  logic        Clk;
  logic        Rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [4:0]  req_rd;
  logic [31:0] req_rs_data;
  logic [31:0] req_rt_data;
  logic        req_rt_valid;
  logic        fwd_valid;
  logic [31:0] fwd_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [15:0] squash_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_sq   = 0;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  rd;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        exp_we;
    logic        exp_sq;
  } vec_t;

  vec_t vecs[9];

  // Reference model: at most one move outstanding, plus its write-port loss count.
  logic        m_busy;
  logic        m_resolved;
  logic [1:0]  m_op;
  logic [4:0]  m_rd;
  logic [31:0] m_rs;
  int          m_losses;
  int          m_sq;
  logic        issue_pending, e_lr, e_we, ld_zero;
  logic [4:0]  e_addr;
  logic [31:0] e_data;

  cmov_wb_ctrl dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_rd       (req_rd),
    .req_rs_data  (req_rs_data),
    .req_rt_data  (req_rt_data),
    .req_rt_valid (req_rt_valid),
    .fwd_valid    (fwd_valid),
    .fwd_data     (fwd_data),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_rd        (ld_rd),
    .ld_data      (ld_data),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .squash_cnt   (squash_cnt)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_op = 2'b00; req_rd = 5'd0; req_rs_data = 32'd0;
    req_rt_data = 32'd0; req_rt_valid = 1'b0; fwd_valid = 1'b0; fwd_data = 32'd0;
    ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'd0;
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] rs,
                           input logic [31:0] rt, input logic rtv);
    req_valid = 1'b1; req_op = op; req_rd = rd; req_rs_data = rs;
    req_rt_data = rt; req_rt_valid = rtv;
  endtask

  function automatic logic wants(input logic [1:0] op, input logic [31:0] rt);
    case (op)
      2'b00:   return 1'b1;
      2'b01:   return rt == 32'd0;
      2'b10:   return rt != 32'd0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic resolve(input logic [31:0] rt);
    logic w;
    w = wants(m_op, rt);
    if (w && m_rd != 5'd0) begin
      m_busy = 1'b1;
      m_resolved = 1'b1;
    end else begin
      m_busy = 1'b0;
      if ((m_op == 2'b01 || m_op == 2'b10) && m_rd != 5'd0 && m_sq < 65535) m_sq++;
    end
  endtask

  initial begin
    vecs[0] = '{2'b01, 5'd5,  32'hDEAD_BEEF, 32'd0,        1'b1, 1'b0};
    vecs[1] = '{2'b10, 5'd7,  32'h0000_1111, 32'd0,        1'b0, 1'b1};
    vecs[2] = '{2'b10, 5'd3,  32'hCAFE_0003, 32'h10,       1'b1, 1'b0};
    vecs[3] = '{2'b01, 5'd9,  32'h0000_0009, 32'd1,        1'b0, 1'b1};
    vecs[4] = '{2'b00, 5'd31, 32'h1357_9BDF, 32'd123,      1'b1, 1'b0};
    vecs[5] = '{2'b00, 5'd0,  32'hFFFF_FFFF, 32'd0,        1'b0, 1'b0};
    vecs[6] = '{2'b11, 5'd4,  32'h4444_4444, 32'd0,        1'b0, 1'b0};
    vecs[7] = '{2'b01, 5'd0,  32'h0000_0077, 32'd1,        1'b0, 1'b0};
    vecs[8] = '{2'b10, 5'd0,  32'h0000_0088, 32'h8000_0000, 1'b0, 1'b0};

    // Reset: outputs quiet even with a load pending.
    idle_inputs();
    Rst_n = 1'b0;
    ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'h55;
    #2;
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_squash", 32'(squash_cnt), 32'd0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    ld_valid = 1'b0;
    #1;
    chk("rel_req_ready", 32'(req_ready), 32'd1);
    chk("rel_rf_we", 32'(rf_we), 32'd0);

    foreach (vecs[i]) begin
      @(negedge Clk);
      drive_req(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].rt, 1'b1);
      #1 chk("tbl_accept_ready", 32'(req_ready), 32'd1);
      @(negedge Clk);
      req_valid = 1'b0;
      if (vecs[i].exp_sq) exp_sq++;
      #1;
      chk("tbl_we", 32'(rf_we), 32'(vecs[i].exp_we));
      chk("tbl_waddr", 32'(rf_waddr), vecs[i].exp_we ? 32'(vecs[i].rd) : 32'd0);
      chk("tbl_wdata", rf_wdata, vecs[i].exp_we ? vecs[i].rs : 32'd0);
      chk("tbl_squash", 32'(squash_cnt), 32'(exp_sq));
      chk("tbl_ready_after", 32'(req_ready), 32'(!vecs[i].exp_we));
      if (vecs[i].exp_we) begin
        @(negedge Clk);
        #1;
        chk("tbl_we_done", 32'(rf_we), 32'd0);
        chk("tbl_ready_done", 32'(req_ready), 32'd1);
      end
    end

    // Late rt: three cycles of waiting, tempting requests must not be taken.
    @(negedge Clk);
    drive_req(2'b01, 5'd10, 32'h1234_5678, 32'hFFFF, 1'b0);
    #1 chk("wait_accept", 32'(req_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      drive_req(2'b00, 5'd20, 32'h0000_FFFF, 32'd0, 1'b1);
      #1;
      chk("wait_ready", 32'(req_ready), 32'd0);
      chk("wait_we", 32'(rf_we), 32'd0);
    end
    @(negedge Clk);
    fwd_valid = 1'b1; fwd_data = 32'd0;
    #1 chk("fwd_ready", 32'(req_ready), 32'd0);
    chk("fwd_we", 32'(rf_we), 32'd0);
    @(negedge Clk);
    req_valid = 1'b0; fwd_valid = 1'b0;
    #1;
    chk("late_we", 32'(rf_we), 32'd1);
    chk("late_waddr", 32'(rf_waddr), 32'd10);
    chk("late_wdata", rf_wdata, 32'h1234_5678);
    @(negedge Clk);
    #1 chk("late_ready_after", 32'(req_ready), 32'd1);
    chk("late_we_after", 32'(rf_we), 32'd0);

    // Arbitration: two load wins, then the move, then loads again.
    @(negedge Clk);
    drive_req(2'b00, 5'd6, 32'h0000_A5A5, 32'd0, 1'b1);
    #1 chk("arb_accept", 32'(req_ready), 32'd1);
    @(negedge Clk);
    req_valid = 1'b0; ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'h111;
    #1 chk("arb_ld1_ready", 32'(ld_ready), 32'd1);
    chk("arb_ld1_waddr", 32'(rf_waddr), 32'd12);
    chk("arb_ld1_wdata", rf_wdata, 32'h111);
    chk("arb_ld1_req_ready", 32'(req_ready), 32'd0);
    @(negedge Clk);
    ld_data = 32'h222;
    #1 chk("arb_ld2_ready", 32'(ld_ready), 32'd1);
    chk("arb_ld2_wdata", rf_wdata, 32'h222);
    @(negedge Clk);
    ld_data = 32'h333;
    #1 chk("arb_issue_ld_ready", 32'(ld_ready), 32'd0);
    chk("arb_issue_we", 32'(rf_we), 32'd1);
    chk("arb_issue_waddr", 32'(rf_waddr), 32'd6);
    chk("arb_issue_wdata", rf_wdata, 32'h0000_A5A5);
    @(negedge Clk);
    #1 chk("arb_ld3_ready", 32'(ld_ready), 32'd1);
    chk("arb_ld3_waddr", 32'(rf_waddr), 32'd12);
    chk("arb_ld3_wdata", rf_wdata, 32'h333);
    chk("arb_req_ready", 32'(req_ready), 32'd1);

    // Load to r0 is granted but never writes.
    @(negedge Clk);
    ld_rd = 5'd0; ld_data = 32'hFF;
    #1 chk("ld0_ready", 32'(ld_ready), 32'd1);
    chk("ld0_we", 32'(rf_we), 32'd0);
    @(negedge Clk);
    idle_inputs();

    // Random traffic against the reference model.
    m_busy = 1'b0; m_resolved = 1'b0; m_losses = 0; m_sq = exp_sq;
    m_op = 2'b00; m_rd = 5'd0; m_rs = 32'd0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge Clk);
      req_valid    = ($urandom_range(0, 1) == 1);
      req_op       = 2'($urandom_range(0, 3));
      req_rd       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      req_rs_data  = $urandom;
      req_rt_data  = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
      req_rt_valid = ($urandom_range(0, 4) < 3);
      fwd_valid    = ($urandom_range(0, 4) < 2);
      fwd_data     = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
      ld_valid     = ($urandom_range(0, 4) < 2);
      ld_rd        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ld_data      = $urandom;
      #1;
      issue_pending = m_busy && m_resolved;
      e_lr = ld_valid && !(issue_pending && m_losses >= 2);
      e_we = 1'b0; e_addr = 5'd0; e_data = 32'd0; ld_zero = 1'b0;
      if (e_lr) begin
        if (ld_rd != 5'd0) begin
          e_we = 1'b1; e_addr = ld_rd; e_data = ld_data;
        end else begin
          ld_zero = 1'b1;
        end
      end else if (issue_pending) begin
        e_we = 1'b1; e_addr = m_rd; e_data = m_rs;
      end
      chk("rnd_req_ready", 32'(req_ready), 32'(!m_busy));
      chk("rnd_ld_ready", 32'(ld_ready), 32'(e_lr));
      chk("rnd_we", 32'(rf_we), 32'(e_we));
      if (!ld_zero) begin
        chk("rnd_waddr", 32'(rf_waddr), 32'(e_addr));
        chk("rnd_wdata", rf_wdata, e_data);
      end
      chk("rnd_squash", 32'(squash_cnt), 32'(m_sq));
      if (issue_pending) begin
        if (e_lr) m_losses++;
        else begin
          m_busy = 1'b0;
          m_losses = 0;
        end
      end else if (m_busy && fwd_valid) begin
        resolve(fwd_data);
      end else if (!m_busy && req_valid) begin
        m_op = req_op; m_rd = req_rd; m_rs = req_rs_data;
        if (req_rt_valid) resolve(req_rt_data);
        else begin
          m_busy = 1'b1;
          m_resolved = 1'b0;
        end
      end
    end
    // Drain any outstanding move before the reset scenarios.
    @(negedge Clk);
    idle_inputs();
    fwd_valid = 1'b1; fwd_data = 32'd1;
    repeat (4) @(negedge Clk);
    fwd_valid = 1'b0;
    m_sq = int'(squash_cnt) > m_sq ? m_sq : m_sq;

    // Reset while waiting for rt discards the move.
    @(negedge Clk);
    drive_req(2'b01, 5'd8, 32'h8888, 32'd0, 1'b0);
    #1 chk("rstw_accept", 32'(req_ready), 32'd1);
    @(negedge Clk);
    req_valid = 1'b0; Rst_n = 1'b0;
    fwd_valid = 1'b1; fwd_data = 32'd0; ld_valid = 1'b1; ld_rd = 5'd3;
    #1 chk("rstw_we", 32'(rf_we), 32'd0);
    chk("rstw_ld_ready", 32'(ld_ready), 32'd0);
    chk("rstw_squash", 32'(squash_cnt), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1; fwd_valid = 1'b0; ld_valid = 1'b0;
    #1 chk("rstw_rel_ready", 32'(req_ready), 32'd1);
    chk("rstw_rel_we", 32'(rf_we), 32'd0);
    @(negedge Clk);
    #1 chk("rstw_rel_we2", 32'(rf_we), 32'd0);
    chk("rstw_rel_squash", 32'(squash_cnt), 32'd0);

    // Reset while in ISSUE discards the write.
    @(negedge Clk);
    drive_req(2'b00, 5'd9, 32'h77, 32'd0, 1'b1);
    @(negedge Clk);
    req_valid = 1'b0; Rst_n = 1'b0;
    #1 chk("rsti_we", 32'(rf_we), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1 chk("rsti_rel_we", 32'(rf_we), 32'd0);
    chk("rsti_rel_ready", 32'(req_ready), 32'd1);

    // Saturation: one false MOVN per cycle.
    for (int i = 0; i < 65540; i++) begin
      @(negedge Clk);
      drive_req(2'b10, 5'd1, 32'h1, 32'd0, 1'b1);
      if (i == 1000 || i == 65535) begin
        #1 chk("sat_progress", 32'(squash_cnt), (i == 1000) ? 32'd1000 : 32'hFFFF);
      end
    end
    @(negedge Clk);
    req_valid = 1'b0;
    #1 chk("sat_final", 32'(squash_cnt), 32'hFFFF);
    chk("sat_no_we", 32'(rf_we), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
